// File: rtl/iir_float_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : iir_float_accumulator
// Brief    : Sequential sign/exponent/mantissa accumulator for IIR tap products
// Revision : 1.0 - initial release
// ============================================================================
module iir_float_accumulator #(
    parameter int EXP_W = 7,
    parameter int MAN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_word,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_word,
    output logic                     overflow
);

    localparam int C_WORD_W = EXP_W + MAN_W + 1;
    localparam logic signed [EXP_W+1:0] C_EXP_MAX = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic signed [EXP_W+1:0] C_EXP_MIN = (EXP_W+2)'(-(2**(EXP_W-1)));
    localparam logic [EXP_W-1:0]        C_SAT_E   = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic signed [EXP_W+1:0] C_ONE_E   = (EXP_W+2)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_NORM  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_op_s;
    logic [EXP_W-1:0]         r_op_e;
    logic [MAN_W-1:0]         r_op_m;
    logic                     r_op_last;
    logic                     r_acc_s;
    logic [EXP_W-1:0]         r_acc_e;
    logic [MAN_W-1:0]         r_acc_m;
    logic                     r_ws;
    logic signed [EXP_W+1:0]  r_we;
    logic [MAN_W:0]           r_wm;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_overflow;

    // Alignment: the operand with the smaller exponent is shifted toward the other.
    logic signed [EXP_W:0]    w_diff;
    logic                     w_acc_big;
    logic [EXP_W:0]           w_shamt;
    logic                     w_big_s;
    logic                     w_sml_s;
    logic [EXP_W-1:0]         w_big_e;
    logic [MAN_W-1:0]         w_big_m;
    logic [MAN_W-1:0]         w_sml_raw;
    logic [MAN_W-1:0]         w_sml_m;
    logic                     w_al_s;
    logic signed [EXP_W+1:0]  w_al_e;
    logic [MAN_W:0]           w_al_m;

    assign w_diff    = $signed({r_acc_e[EXP_W-1], r_acc_e}) - $signed({r_op_e[EXP_W-1], r_op_e});
    assign w_acc_big = ~w_diff[EXP_W];
    assign w_shamt   = w_acc_big ? w_diff : -w_diff;
    assign w_big_s   = w_acc_big ? r_acc_s : r_op_s;
    assign w_sml_s   = w_acc_big ? r_op_s  : r_acc_s;
    assign w_big_e   = w_acc_big ? r_acc_e : r_op_e;
    assign w_big_m   = w_acc_big ? r_acc_m : r_op_m;
    assign w_sml_raw = w_acc_big ? r_op_m  : r_acc_m;
    assign w_sml_m   = (w_shamt > (EXP_W+1)'(MAN_W)) ? '0 : (w_sml_raw >> w_shamt);

    always_comb begin
        w_al_s = 1'b0;
        w_al_e = $signed({{2{w_big_e[EXP_W-1]}}, w_big_e});
        w_al_m = '0;
        if (r_op_m == '0) begin
            w_al_s = r_acc_s;
            w_al_e = $signed({{2{r_acc_e[EXP_W-1]}}, r_acc_e});
            w_al_m = {1'b0, r_acc_m};
        end else if (r_acc_m == '0) begin
            w_al_s = r_op_s;
            w_al_e = $signed({{2{r_op_e[EXP_W-1]}}, r_op_e});
            w_al_m = {1'b0, r_op_m};
        end else if (w_big_s == w_sml_s) begin
            w_al_s = w_big_s;
            w_al_m = {1'b0, w_big_m} + {1'b0, w_sml_m};
        end else if (w_big_m > w_sml_m) begin
            w_al_s = w_big_s;
            w_al_m = {1'b0, w_big_m - w_sml_m};
        end else if (w_sml_m > w_big_m) begin
            w_al_s = w_sml_s;
            w_al_m = {1'b0, w_sml_m - w_big_m};
        end
    end

    // Normalisation step: decides whether this cycle commits and with what value.
    logic                     w_commit;
    logic                     w_czero;
    logic signed [EXP_W+1:0]  w_ce;
    logic [MAN_W-1:0]         w_cm;
    logic                     w_sat;
    logic                     w_flush;

    always_comb begin
        w_commit = 1'b0;
        w_czero  = 1'b0;
        w_ce     = r_we;
        w_cm     = r_wm[MAN_W-1:0];
        if (r_wm[MAN_W]) begin
            w_commit = 1'b1;
            w_cm     = r_wm[MAN_W:1];
            w_ce     = r_we + C_ONE_E;
        end else if (r_wm == '0) begin
            w_commit = 1'b1;
            w_czero  = 1'b1;
        end else if (r_wm[MAN_W-1]) begin
            w_commit = 1'b1;
        end
    end

    assign w_sat   = (w_ce > C_EXP_MAX);
    assign w_flush = (w_ce < C_EXP_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op_s      <= 1'b0;
            r_op_e      <= '0;
            r_op_m      <= '0;
            r_op_last   <= 1'b0;
            r_acc_s     <= 1'b0;
            r_acc_e     <= '0;
            r_acc_m     <= '0;
            r_ws        <= 1'b0;
            r_we        <= '0;
            r_wm        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_op_s     <= in_word[C_WORD_W-1];
                        r_op_e     <= in_word[C_WORD_W-2:MAN_W];
                        r_op_m     <= in_word[MAN_W-1:0];
                        r_op_last  <= in_last;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_ws    <= w_al_s;
                    r_we    <= w_al_e;
                    r_wm    <= w_al_m;
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (w_commit) begin
                        if (w_czero || w_flush) begin
                            r_acc_s <= 1'b0;
                            r_acc_e <= '0;
                            r_acc_m <= '0;
                        end else if (w_sat) begin
                            r_acc_s    <= r_ws;
                            r_acc_e    <= C_SAT_E;
                            r_acc_m    <= '1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_acc_s <= r_ws;
                            r_acc_e <= w_ce[EXP_W-1:0];
                            r_acc_m <= w_cm;
                        end
                        if (r_op_last) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end else begin
                        r_wm <= r_wm << 1;
                        r_we <= r_we - C_ONE_E;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_acc_s     <= 1'b0;
                        r_acc_e     <= '0;
                        r_acc_m     <= '0;
                        r_overflow  <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_word  = {r_acc_s, r_acc_e, r_acc_m};
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_iir_float_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_float_accumulator
// Brief    : Directed and random frames against an integer-arithmetic model
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_float_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_word = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic        overflow;
    logic [15:0] out_word;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] m_acc = 16'h0000;
    bit          m_ovf = 1'b0;

    iir_float_accumulator #(.EXP_W(7), .MAN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sum as signed integers on a common exponent, then renormalise.
    function automatic void model_add(input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output bit ovf, output int nsh);
        int ae, be, e, ma, mb, sum, m;
        bit s;
        ae  = int'($signed(a[14:8]));
        be  = int'($signed(b[14:8]));
        ovf = 1'b0;
        nsh = 0;
        s   = 1'b0;
        if (b[7:0] == 8'd0) begin
            s = a[15]; e = ae; m = int'(a[7:0]);
        end else if (a[7:0] == 8'd0) begin
            s = b[15]; e = be; m = int'(b[7:0]);
        end else begin
            e   = (ae > be) ? ae : be;
            ma  = (e - ae > 8) ? 0 : (int'(a[7:0]) >> (e - ae));
            mb  = (e - be > 8) ? 0 : (int'(b[7:0]) >> (e - be));
            sum = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
            s   = (sum < 0);
            m   = s ? -sum : sum;
        end
        if (m == 0) begin
            r = 16'h0000;
        end else begin
            if (m > 255) begin
                m = m >> 1;
                e = e + 1;
            end
            while (m < 128) begin
                m = m << 1;
                e = e - 1;
                nsh++;
            end
            if (e > 63) begin
                r   = {s, 7'h3F, 8'hFF};
                ovf = 1'b1;
            end else if (e < -64) begin
                r = 16'h0000;
            end else begin
                r = {s, 7'(e), 8'(m)};
            end
        end
    endfunction

    function automatic logic [15:0] rand_word();
        int         sel;
        logic [6:0] e;
        logic [7:0] m;
        sel = int'($urandom_range(0, 9));
        e   = 7'(int'($urandom_range(0, 8)) - 4);
        m   = 8'($urandom_range(128, 255));
        case (sel)
            0: m = 8'h00;
            1: m = 8'($urandom_range(1, 127));
            2: e = 7'($urandom_range(0, 127));
            default: ;
        endcase
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    task automatic push(input logic [15:0] w, input bit last);
        logic [15:0] r;
        bit          o;
        int          nsh;
        int          t;
        int          cyc;
        model_add(m_acc, w, r, o, nsh);
        m_acc = r;
        m_ovf = m_ovf | o;
        t = 0;
        while (in_ready !== 1'b1 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid  = 1'b1;
        in_word   = w;
        in_last   = last;
        out_ready = last ? 1'b0 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_word  = 16'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        check("busy_after_accept", in_ready, 0);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(last ? (out_valid === 1'b1) : (in_ready === 1'b1)) && cyc < 20);
        check(last ? "latency_last" : "latency", cyc, 2 + nsh);
        out_ready = 1'b0;
    endtask

    task automatic pop(input int hold, input bit use_exp, input logic [15:0] ew, input bit eo);
        logic [15:0] xw;
        bit          xo;
        xw = use_exp ? ew : m_acc;
        xo = use_exp ? eo : m_ovf;
        check("out_valid", out_valid, 1);
        check("out_word", out_word, xw);
        check("overflow", overflow, xo);
        check("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_word", out_word, xw);
            check("hold_ovf", overflow, xo);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("ready_back", in_ready, 1);
        check("ovf_clear", overflow, 0);
        m_acc = 16'h0000;
        m_ovf = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word", out_word, 16'h0000);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        push(16'h00C0, 1'b1); pop(0, 1'b1, 16'h00C0, 1'b0);
        push(16'h0080, 1'b0); push(16'h0080, 1'b1); pop(0, 1'b1, 16'h0180, 1'b0);
        push(16'h00C0, 1'b0); push(16'h8080, 1'b1); pop(0, 1'b1, 16'h7F80, 1'b0);
        push(16'h0180, 1'b0); push(16'h7F80, 1'b1); pop(0, 1'b1, 16'h01A0, 1'b0);
        push(16'h0080, 1'b0); push(16'h8080, 1'b1); pop(0, 1'b1, 16'h0000, 1'b0);
        push(16'h0080, 1'b0); push(16'h7680, 1'b1); pop(0, 1'b1, 16'h0080, 1'b0);
        push(16'h3FFF, 1'b0); push(16'h3FFF, 1'b1); pop(5, 1'b1, 16'h3FFF, 1'b1);
        push(16'h0080, 1'b1); pop(0, 1'b1, 16'h0080, 1'b0);
        push(16'h4080, 1'b0); push(16'hC040, 1'b1); pop(0, 1'b1, 16'h0000, 1'b0);
        push(16'h0001, 1'b1); pop(1, 1'b1, 16'h7980, 1'b0);

        // Asynchronous reset while the normaliser is still shifting.
        in_valid = 1'b1;
        in_word  = 16'h0001;
        in_last  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midnorm_in_ready", in_ready, 1);
        check("midnorm_out_valid", out_valid, 0);
        check("midnorm_out_word", out_word, 16'h0000);
        check("midnorm_overflow", overflow, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_acc = 16'h0000;
        m_ovf = 1'b0;
        push(16'h00C0, 1'b1); pop(0, 1'b1, 16'h00C0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
                push(rand_word(), k == n - 1);
            end
            pop(int'($urandom_range(0, 3)), 1'b0, 16'h0000, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
